// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types and constants: column-word state, FSM encoding,
// inverse S-box and the GF(2^8) doubling primitive.
package aes_dec_pkg;

  localparam int NR = 10;

  // Word 0 is column 0 and sits in bits [127:96]; byte [31:24] of a word is row 0.
  typedef logic [0:3][31:0] state_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  // Element 0 is the most significant byte, so the table reads in natural order.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// InvMixColumns on one column: multiply by the circulant {0e,0b,0d,09}.
module inv_mix_col
  import aes_dec_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  assign mixed = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                  m9[0] ^ me[1] ^ mb[2] ^ md[3],
                  md[0] ^ m9[1] ^ me[2] ^ mb[3],
                  mb[0] ^ md[1] ^ m9[2] ^ me[3]};

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both
// sides; round keys come from an external store addressed by rk_addr_o.
module aes_inv_cipher
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic [3:0]   rk_addr_o,
  input  logic [127:0] rk_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  fsm_e       state_q, state_d;
  logic [3:0] round_q;
  state_t     st_q, shifted, subbed, ark, mixed;
  logic       accept, last_round, out_fire;

  assign accept     = in_valid_i && (state_q == IDLE);
  assign last_round = (round_q == 4'd0);
  assign out_fire   = (state_q == DONE) && out_ready_i;

  // InvShiftRows: output column c, row r takes input column (c - r) mod 4.
  always_comb begin
    shifted = '0;
    subbed  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[c][31-8*r -: 8] = st_q[(c + 4 - r) % 4][31-8*r -: 8];
        subbed[c][31-8*r -: 8]  = INV_SBOX[shifted[c][31-8*r -: 8]];
      end
    end
  end

  assign ark = subbed ^ rk_data_i;

  for (genvar g = 0; g < 4; g++) begin : g_mix
    inv_mix_col u_mix (
      .col   (ark[g]),
      .mixed (mixed[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = ROUND;
      ROUND:   if (last_round) state_d = DONE;
      DONE:    if (out_fire)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    out_valid_o = (state_q == DONE);
    rk_addr_o   = round_q;
  end

  // Round counter doubles as the key address; it parks at 0 through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= 4'(NR);
      st_q    <= '0;
      data_o  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          st_q    <= data_i ^ rk_data_i;
          round_q <= 4'(NR - 1);
        end
        ROUND: begin
          if (last_round) begin
            st_q   <= ark;
            data_o <= ark;
          end else begin
            st_q    <= mixed;
            round_q <= round_q - 4'd1;
          end
        end
        DONE: if (out_fire) round_q <= 4'(NR);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors through a table, an independent
// key-schedule model as the key store, and a scoreboard on the output handshake.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_in, rk_data, data_out;
  logic [3:0]   rk_addr;

  logic [127:0] rk_tab [0:15];
  logic [7:0]   sbox_f [0:255];
  logic [127:0] exp_q [$];
  int           n_cmp = 0;
  int           n_err = 0;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           bp;
  } vec_t;

  always #5 clk = ~clk;

  assign rk_data = rk_tab[rk_addr];

  aes_inv_cipher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data_in),
    .rk_addr_o   (rk_addr),
    .rk_data_i   (rk_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_out),
    .busy_o      (busy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} >> (8 - n);
    return d[7:0];
  endfunction

  // Forward S-box from the field inverse and affine map, for key expansion only.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_f[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_f[t[31:24]], sbox_f[t[23:16]], sbox_f[t[15:8]], sbox_f[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Count edges from the current cycle until out_valid, checking key addresses on the way.
  task automatic wait_done(input string nm);
    int lat = 0;
    int ea  = 9;
    bit ok  = 1'b1;
    while (!out_valid && lat < 30) begin
      if (rk_addr !== 4'(ea) || busy !== 1'b1) ok = 1'b0;
      ea--;
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'd10);
    chk({nm, "_rk_seq"}, 128'(ok), 128'd1);
  endtask

  task automatic run_block(input string nm, input logic [127:0] ct, input logic [127:0] pt, input int bp);
    int t = 0;
    in_valid  = 1'b1;
    data_in   = ct;
    out_ready = 1'b0;
    while (!in_ready && t < 30) begin tick(); t++; end
    if (t >= 30) begin
      chk({nm, "_accept_timeout"}, 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    chk({nm, "_rk_idle"}, 128'(rk_addr), 128'd10);
    exp_q.push_back(pt);
    tick();
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    wait_done(nm);
    for (int i = 0; i < bp; i++) begin
      chk({nm, "_hold_data"}, data_out, pt);
      chk({nm, "_hold_ready"}, {126'h0, in_ready, out_valid}, 128'h1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_post_hs"}, {125'h0, in_ready, out_valid, busy}, 128'h4);
    chk({nm, "_rk_rearm"}, 128'(rk_addr), 128'd10);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", data_out, 128'hx);
      else                   chk("sb_plaintext", data_out, exp_q.pop_front());
    end
  end

  initial begin
    vec_t vecs [3];
    vecs[0] = '{"c1",    KEY_C1, CT_C1, PT_C1, 0};
    vecs[1] = '{"b_bp5", KEY_B,  CT_B,  PT_B,  5};
    vecs[2] = '{"c1_bp2",KEY_C1, CT_C1, PT_C1, 2};

    build_sbox();
    load_key(KEY_C1);
    chk("keymodel_rk10", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    rst_n     = 1'b0;
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    data_in   = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {125'h0, in_ready, out_valid, busy}, 128'h4);
    chk("rst_rk_addr", 128'(rk_addr), 128'd10);
    chk("rst_data_o", data_out, 128'h0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key);
      run_block(vecs[i].name, vecs[i].ct, vecs[i].pt, vecs[i].bp);
    end

    // Back-to-back: valid held high, second ciphertext parked on data_i mid-flight.
    load_key(KEY_C1);
    in_valid  = 1'b1;
    data_in   = CT_C1;
    out_ready = 1'b1;
    exp_q.push_back(PT_C1);
    tick();
    data_in = CT_B;
    wait_done("b2b_first");
    load_key(KEY_B);
    chk("b2b_busy_ready", 128'(in_ready), 128'd0);
    tick();
    chk("b2b_gap", {126'h0, in_ready, busy}, 128'h2);
    exp_q.push_back(PT_B);
    tick();
    in_valid = 1'b0;
    wait_done("b2b_second");
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", 128'(in_ready), 128'd1);

    // Mid-operation reset while round 5 is being processed.
    load_key(KEY_C1);
    in_valid = 1'b1;
    data_in  = CT_C1;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 30 && rk_addr != 4'd5; t++) tick();
    chk("mrst_reached5", 128'(rk_addr), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("mrst_flags", {125'h0, in_ready, out_valid, busy}, 128'h4);
    chk("mrst_rk_addr", 128'(rk_addr), 128'd10);
    chk("mrst_data_o", data_out, 128'h0);
    #1;
    rst_n = 1'b1;
    tick();
    run_block("post_rst_c1", CT_C1, PT_C1, 1);

    tick();
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block over a valid/ready handshake, runs the FIPS-197 inverse cipher at one round per clock, and returns the plaintext over a second valid/ready handshake. It sits on the decryption side of the cipher unit, next to the encryption datapath. It shares that datapath's column-word state layout and reads round keys from the external key-schedule store through a combinational-read port.

## Interface
- Parameters: none. AES-128 only; round count `NR` = 10 is a package constant.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `in_valid_i` in 1: ciphertext offered.
- `in_ready_o` out 1: block can accept. Reset 1.
- `data_i` in 128: ciphertext, FIPS byte order. `[127:96]` is column 0.
- `rk_addr_o` out 4: round-key index requested. Reset 10.
- `rk_data_i` in 128: round key `rk_addr_o`. Combinational, valid in the same cycle.
- `out_valid_o` out 1: plaintext available. Reset 0.
- `out_ready_i` in 1: consumer takes plaintext.
- `data_o` out 128: plaintext, same byte order as `data_i`. Reset 0.
- `busy_o` out 1: a block is in flight (ROUND or DONE). Reset 0.

## Operation
- State is held as four 32-bit words; word `i` = column `i`, and byte `[31:24]` = row 0.
- FSM states and transitions:
  - IDLE → ROUND on accept (`in_valid_i && in_ready_o`).
  - ROUND → DONE when round counter = 0.
  - DONE → IDLE on `out_valid_o && out_ready_i`.
- Accept edge:
  - state ← `data_i ^ rk_data_i`; round key 10 is on the port because `rk_addr_o` = 10 throughout IDLE.
  - round ← 9.
- ROUND with round r ≥ 1: state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])); round ← r−1.
- ROUND with r = 0: state ← AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]). At the same edge, `data_o` ← result, `out_valid_o` ← 1, go to DONE.
- InvShiftRows: row k rotates right by k columns. Output column c, row k takes input column (c−k) mod 4.
- `rk_addr_o` = round register, so the sequence per block is 10, 9, …, 1, 0. The register is set back to 10 on leaving DONE.
- In DONE, `data_o` and `out_valid_o` hold until the output handshake.
- `in_ready_o` = (FSM == IDLE). There is no overlap: a new block is accepted only after the previous output handshake.
- `in_valid_i` is ignored outside IDLE. `out_ready_i` is ignored unless `out_valid_o` = 1.
- On `rst_n` low, at any time including mid-round:
  - FSM → IDLE, round → 10, state and `data_o` → 0.
  - `out_valid_o` = 0, `busy_o` = 0, `in_ready_o` = 1.
  - The in-flight block is discarded, with no partial output.

## Timing
- Latency is exactly 10 edges from the accept edge E0 to the edge that sets `out_valid_o`.
  - E1–E9 perform rounds 9..1.
  - E10 performs the final round and raises `out_valid_o`.
- `rk_addr_o` changes only on clock edges (registered). The key store may use it as a stable address for a full cycle.
- After the output handshake edge, `in_ready_o` = 1 in the next cycle. Minimum initiation interval is 12 cycles.
- All outputs are registered or decoded from FSM registers only. There is no combinational path from `in_valid_i` or `out_ready_i` to any output.

## Structure
- Package `aes_dec_pkg` holds:
  - `NR` = 10.
  - State typedef: four 32-bit column words.
  - FSM enum {IDLE, ROUND, DONE}.
  - `INV_SBOX` 256×8 constant.
  - `xtime` GF(2^8) function.
- Sub-module `inv_mix_col`:
  - One 32-bit column in, one out.
  - Multiplies by {0e, 0b, 0d, 09} via `xtime` chains.
  - Instantiated four times.
- InvShiftRows, InvSubBytes (16 `INV_SBOX` lookups) and AddRoundKey are inline in the top.

## Test plan
- Reset: assert `rst_n` = 0 with random inputs → `in_ready_o` = 1, `out_valid_o` = 0, `busy_o` = 0, `rk_addr_o` = 10, `data_o` = 0.
- FIPS-197 C.1:
  - Setup: key 000102…0f; bench key model supplies rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Stimulus: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required response: `data_o` = 00112233445566778899aabbccddeeff, `out_valid_o` rises exactly 10 edges after accept, and `rk_addr_o` sequence is 10..0.
- FIPS-197 B with backpressure:
  - Setup: key 2b7e151628aed2a6abf7158809cf4f3c; ct 3925841d02dc09fbdc118597196a0b32.
  - Stimulus: hold `out_ready_i` = 0 for 5 cycles.
  - Required response: `data_o` = 3243f6a8885a308d313198a2e0370734, held stable with `in_ready_o` = 0 throughout; `in_ready_o` = 1 one cycle after the handshake.
- Back-to-back: keep `in_valid_i` high with C.1 then B ciphertexts.
  - Second block is accepted only in the cycle after the first output handshake.
  - Both plaintexts are correct.
  - Mid-flight `data_i` changes have no effect.
- Mid-operation reset: pulse `rst_n` low while `rk_addr_o` = 5.
  - Required response: immediate IDLE, `out_valid_o` = 0, `rk_addr_o` = 10.
  - A following C.1 decrypt is correct with 10-edge latency.
